// File: rtl/chip_gate_checker.sv
// Generic 74xx 2-input gate package checker: walks all four input vectors across
// every gate, samples synchronised outputs and reports pass/fail with diagnostics.
module chip_gate_checker #(
    parameter int NUM_GATES     = 4,
    parameter int GATE_FN       = 0,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 DISP_RSLT,
    output logic [NUM_GATES-1:0] PinA,
    output logic [NUM_GATES-1:0] PinB,
    input  logic [NUM_GATES-1:0] PinY,
    output logic                 Done,
    output logic                 RSLT,
    output logic [NUM_GATES-1:0] FAIL_MASK,
    output logic [1:0]           FAIL_VEC,
    output logic                 FAIL_VALID
);

    generate
        if (NUM_GATES < 1 || NUM_GATES > 8) begin : g_bad_num_gates
            $error("chip_gate_checker: NUM_GATES must be 1..8");
        end
        if (GATE_FN < 0 || GATE_FN > 4) begin : g_bad_gate_fn
            $error("chip_gate_checker: GATE_FN must be 0..4");
        end
        if (SETTLE_CYCLES < 2) begin : g_bad_settle
            $error("chip_gate_checker: SETTLE_CYCLES must be >= 2");
        end
    endgenerate

    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] HALTED = 3'd0;
    localparam logic [2:0] SET    = 3'd1;
    localparam logic [2:0] DRIVE  = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]           state;
    logic [1:0]           vec;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_GATES-1:0] y_meta;
    logic [NUM_GATES-1:0] y_s;
    logic [NUM_GATES-1:0] expected;
    logic [NUM_GATES-1:0] mismatch;
    logic                 driving;

    function automatic logic gate_out(input logic a, input logic b);
        case (GATE_FN)
            0:       return ~(a & b);
            1:       return ~(a | b);
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 1'b0;
        endcase
    endfunction

    // PinY is asynchronous to Clk; only the second flop is ever compared.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            y_meta <= '0;
            y_s    <= '0;
        end else begin
            y_meta <= PinY;
            y_s    <= y_meta;
        end
    end

    always_comb begin
        expected = {NUM_GATES{gate_out(vec[1], vec[0])}};
        mismatch = y_s ^ expected;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= HALTED;
            vec        <= '0;
            cnt        <= '0;
            RSLT       <= 1'b0;
            FAIL_MASK  <= '0;
            FAIL_VEC   <= '0;
            FAIL_VALID <= 1'b0;
        end else begin
            case (state)
                HALTED: begin
                    if (Run) begin
                        state <= SET;
                    end
                end
                SET: begin
                    RSLT       <= 1'b1;
                    FAIL_MASK  <= '0;
                    FAIL_VEC   <= '0;
                    FAIL_VALID <= 1'b0;
                    vec        <= '0;
                    cnt        <= RELOAD;
                    state      <= DRIVE;
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    FAIL_MASK <= FAIL_MASK | mismatch;
                    if (|mismatch) begin
                        RSLT <= 1'b0;
                        // Only the first failing vector is kept for diagnosis.
                        if (!FAIL_VALID) begin
                            FAIL_VEC   <= vec;
                            FAIL_VALID <= 1'b1;
                        end
                    end
                    if (vec == 2'b11) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + 2'd1;
                        cnt   <= RELOAD;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    if (DISP_RSLT) begin
                        state <= HALTED;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

    always_comb begin
        driving = (state == DRIVE) || (state == SAMPLE);
        PinA    = driving ? {NUM_GATES{vec[1]}} : '0;
        PinB    = driving ? {NUM_GATES{vec[0]}} : '0;
        Done    = (state == DONE);
    end

endmodule

// File: tb/tb_chip_gate_checker.sv
// Randomised self-checking bench for chip_gate_checker using a faulty-chip model
// and a vector-level reference that predicts RSLT/FAIL_* and Done timing.
module tb_chip_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, run0, disp0, run1, disp1;
    logic [3:0] pa0, pb0, py0, fm0;
    logic       done0, rslt0, fval0;
    logic [1:0] fv0;
    logic [5:0] pa1, pb1, py1, fm1;
    logic       done1, rslt1, fval1;
    logic [1:0] fv1;

    // Fault codes per gate: 0 good, 1 stuck-0, 2 stuck-1, 3 inverted, 4 behaves as NOR
    int flt0[8];
    int flt1[8];

    int n_cmp = 0;
    int n_mis = 0;

    chip_gate_checker #(.NUM_GATES(4), .GATE_FN(0), .SETTLE_CYCLES(4)) u_nand (
        .Clk(clk), .Reset(rst), .Run(run0), .DISP_RSLT(disp0),
        .PinA(pa0), .PinB(pb0), .PinY(py0), .Done(done0), .RSLT(rslt0),
        .FAIL_MASK(fm0), .FAIL_VEC(fv0), .FAIL_VALID(fval0)
    );

    chip_gate_checker #(.NUM_GATES(6), .GATE_FN(4), .SETTLE_CYCLES(2)) u_xor (
        .Clk(clk), .Reset(rst), .Run(run1), .DISP_RSLT(disp1),
        .PinA(pa1), .PinB(pb1), .PinY(py1), .Done(done1), .RSLT(rslt1),
        .FAIL_MASK(fm1), .FAIL_VEC(fv1), .FAIL_VALID(fval1)
    );

    function automatic logic ideal(input int fn, input logic a, input logic b);
        case (fn)
            0:       return ~(a & b);
            1:       return ~(a | b);
            2:       return a & b;
            3:       return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic chip_bit(input int fn, input int f, input logic a, input logic b);
        case (f)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~ideal(fn, a, b);
            4:       return ~(a | b);
            default: return ideal(fn, a, b);
        endcase
    endfunction

    always_comb begin
        py0 = '0;
        for (int i = 0; i < 4; i++) py0[i] = chip_bit(0, flt0[i], pa0[i], pb0[i]);
    end

    always_comb begin
        py1 = '0;
        for (int i = 0; i < 6; i++) py1[i] = chip_bit(4, flt1[i], pa1[i], pb1[i]);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap(input int inst, output logic [7:0] pa, output logic [7:0] pb,
                        output logic [7:0] fm, output logic dn, output logic rs,
                        output logic fl, output logic [1:0] fv);
        if (inst == 0) begin
            pa = {4'b0, pa0}; pb = {4'b0, pb0}; fm = {4'b0, fm0};
            dn = done0; rs = rslt0; fl = fval0; fv = fv0;
        end else begin
            pa = {2'b0, pa1}; pb = {2'b0, pb1}; fm = {2'b0, fm1};
            dn = done1; rs = rslt1; fl = fval1; fv = fv1;
        end
    endtask

    // Reference: apply every vector to the modelled chip and compare with the ideal gate.
    task automatic predict(input int inst, output logic [7:0] mask, output logic [1:0] fvec,
                           output logic fvalid);
        int fn, n, f;
        logic [1:0] v;
        logic any;
        fn = (inst == 0) ? 0 : 4;
        n  = (inst == 0) ? 4 : 6;
        mask = '0; fvec = '0; fvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            any = 1'b0;
            for (int g = 0; g < n; g++) begin
                f = (inst == 0) ? flt0[g] : flt1[g];
                if (chip_bit(fn, f, v[1], v[0]) != ideal(fn, v[1], v[0])) begin
                    mask[g] = 1'b1;
                    any = 1'b1;
                end
            end
            if (any && !fvalid) begin
                fvec = v;
                fvalid = 1'b1;
            end
        end
    endtask

    task automatic run_inst(input int inst, output int cyc);
        int s, n;
        logic [7:0] pa, pb, fm, full;
        logic dn, rs, fl;
        logic [1:0] fv, v;
        s = (inst == 0) ? 4 : 2;
        n = (inst == 0) ? 4 : 6;
        full = 8'((1 << n) - 1);
        @(negedge clk);
        if (inst == 0) run0 = 1'b1; else run1 = 1'b1;
        @(negedge clk);
        run0 = 1'b0; run1 = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            snap(inst, pa, pb, fm, dn, rs, fl, fv);
            if (cyc == 2) begin
                check_eq("set_rslt", 32'(rs), 32'd1);
                check_eq("set_mask", 32'(fm), 32'd0);
                check_eq("set_fval", 32'(fl), 32'd0);
            end
            for (int k = 0; k < 4; k++) begin
                v = 2'(k);
                if (cyc == 2 + k * (s + 1) || cyc == 2 + k * (s + 1) + s) begin
                    check_eq("pin_a", 32'(pa), 32'(v[1] ? full : 8'h00));
                    check_eq("pin_b", 32'(pb), 32'(v[0] ? full : 8'h00));
                end
            end
            if (dn) break;
            @(negedge clk);
            cyc++;
        end
        check_eq("done_cycle", 32'(cyc), 32'(2 + 4 * (s + 1)));
    endtask

    task automatic check_result(input int inst, input string tag);
        logic [7:0] m, pa, pb, fm;
        logic [1:0] efv, fv;
        logic efl, dn, rs, fl;
        predict(inst, m, efv, efl);
        snap(inst, pa, pb, fm, dn, rs, fl, fv);
        check_eq({tag, "_rslt"}, 32'(rs), 32'(m == 8'h00));
        check_eq({tag, "_mask"}, 32'(fm), 32'(m));
        check_eq({tag, "_fval"}, 32'(fl), 32'(efl));
        check_eq({tag, "_fvec"}, 32'(fv), 32'(efv));
        check_eq({tag, "_pins_idle"}, 32'({pa, pb}), 32'd0);
    endtask

    task automatic release_inst(input int inst);
        logic [7:0] pa, pb, fm;
        logic dn, rs, fl;
        logic [1:0] fv;
        @(negedge clk);
        if (inst == 0) disp0 = 1'b1; else disp1 = 1'b1;
        @(negedge clk);
        disp0 = 1'b0; disp1 = 1'b0;
        snap(inst, pa, pb, fm, dn, rs, fl, fv);
        check_eq("release_done", 32'(dn), 32'd0);
    endtask

    task automatic rand_faults(input int inst);
        int f;
        for (int g = 0; g < 8; g++) begin
            f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            if (inst == 0) flt0[g] = (g < 4) ? f : 0;
            else           flt1[g] = (g < 6) ? f : 0;
        end
    endtask

    initial begin
        int cyc;
        logic [7:0] pa, pb, fm;
        logic dn, rs, fl;
        logic [1:0] fv;
        rst = 1'b1; run0 = 1'b0; disp0 = 1'b0; run1 = 1'b0; disp1 = 1'b0;
        for (int g = 0; g < 8; g++) begin flt0[g] = 0; flt1[g] = 0; end
        repeat (3) @(negedge clk);
        snap(0, pa, pb, fm, dn, rs, fl, fv);
        check_eq("rst_done", 32'(dn), 32'd0);
        check_eq("rst_rslt", 32'(rs), 32'd0);
        check_eq("rst_mask", 32'(fm), 32'd0);
        check_eq("rst_fail", 32'({fl, fv}), 32'd0);
        check_eq("rst_pins", 32'({pa, pb}), 32'd0);
        snap(1, pa, pb, fm, dn, rs, fl, fv);
        check_eq("rst_xor", 32'({dn, rs, fl, fv, fm}), 32'd0);
        rst = 1'b0;

        // Good NAND package
        run_inst(0, cyc);
        check_result(0, "t1");
        release_inst(0);

        // Gate 2 stuck at 1, then the result handshake with a spurious Run in DONE
        flt0[2] = 2;
        run_inst(0, cyc);
        check_result(0, "t2");
        check_eq("t2_mask_abs", 32'(fm0), 32'h4);
        check_eq("t2_fvec_abs", 32'(fv0), 32'h3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run0 = (i == 3);
            check_eq("t5_hold_done", 32'(done0), 32'd1);
        end
        run0 = 1'b0;
        release_inst(0);
        check_eq("t5_keep_rslt", 32'(rslt0), 32'd0);
        check_eq("t5_keep_mask", 32'(fm0), 32'h4);
        repeat (3) @(negedge clk);
        check_eq("t5_no_restart", 32'({done0, pa0, pb0}), 32'd0);

        // Gate 0 stuck at 0 and gate 3 inverted: first failing vector must be 00
        flt0[2] = 0; flt0[0] = 1; flt0[3] = 3;
        run_inst(0, cyc);
        check_result(0, "t3");
        check_eq("t3_mask_abs", 32'(fm0), 32'h9);
        check_eq("t3_fvec_abs", 32'(fv0), 32'h0);
        release_inst(0);

        // Reset in the middle of vector 10's drive window
        flt0[0] = 0; flt0[3] = 0; flt0[1] = 1;
        @(negedge clk); run0 = 1'b1;
        @(negedge clk); run0 = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("t4_pre_pins", 32'({pa0, pb0}), 32'hF0);
        check_eq("t4_pre_mask", 32'(fm0), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t4_rst_outs", 32'({done0, rslt0, fval0, fv0, fm0, pa0, pb0}), 32'd0);
        flt0[1] = 0;
        run_inst(0, cyc);
        check_result(0, "t4");
        release_inst(0);

        for (int it = 0; it < 8; it++) begin
            rand_faults(0);
            run_inst(0, cyc);
            check_result(0, "rnd_nand");
            release_inst(0);
        end

        // XOR package, six gates, short settle
        run_inst(1, cyc);
        check_result(1, "t6_good");
        release_inst(1);
        flt1[5] = 4;
        run_inst(1, cyc);
        check_result(1, "t6_nor");
        check_eq("t6_mask_abs", 32'(fm1), 32'h20);
        check_eq("t6_fvec_abs", 32'(fv1), 32'h0);
        release_inst(1);

        for (int it = 0; it < 6; it++) begin
            rand_faults(1);
            run_inst(1, cyc);
            check_result(1, "rnd_xor");
            release_inst(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
